// File: rtl/simd_mem_responder.sv
// simd_mem_responder: program loader, instruction fetch and data memory responder for a SIMD core
module simd_mem_responder #(
  parameter int DATA_DEPTH = 1024,
  parameter int INST_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  inst_adds,
  output logic [17:0] inst_in,
  input  logic        data_R,
  input  logic        data_W,
  input  logic [9:0]  data_adds,
  input  logic [7:0]  data_out,
  output logic [7:0]  data_in,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [9:0]  ld_addr,
  input  logic [17:0] ld_data,
  input  logic        ld_last,
  input  logic        reload,
  input  logic        done,
  output logic        cpu_start,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);
  localparam int DAW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int IAW = (INST_DEPTH > 1) ? $clog2(INST_DEPTH) : 1;

  typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [17:0] inst_in_q, inst_in_d;
  logic [7:0]  data_in_q, data_in_d;
  logic        err_q, err_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  logic [7:0]  dmem [0:(1<<DAW)-1];
  logic [17:0] imem [0:(1<<IAW)-1];

  logic load, run, ld_fire, ld_ok, i_ok, d_ok, rd_acc, wr_acc, clr;

  // next state, clears on re-entry to LOAD, fetch/read data, saturating counters, sticky error
  always_comb begin
    load       = state_q == LOAD;
    run        = state_q == RUN;
    ld_fire    = load && ld_valid;
    ld_ok      = 32'(ld_addr) < INST_DEPTH;
    i_ok       = 32'(inst_adds) < INST_DEPTH;
    d_ok       = 32'(data_adds) < DATA_DEPTH;
    rd_acc     = run && data_R;
    wr_acc     = run && data_W;
    state_d    = (ld_fire && ld_last) ? RUN :
                 (!load && reload)    ? LOAD :
                 (run && done)        ? HALT : state_q;
    clr        = !load && state_d == LOAD;
    inst_in_d  = (run && state_d == RUN && i_ok) ? imem[inst_adds[IAW-1:0]] : '0;
    data_in_d  = clr     ? '0 :
                 !rd_acc ? data_in_q :
                 !d_ok   ? '0 :
                 data_W  ? data_out : dmem[data_adds[DAW-1:0]];
    rd_count_d = clr ? '0 : (rd_acc && rd_count_q != 16'hFFFF) ? rd_count_q + 16'd1 : rd_count_q;
    wr_count_d = clr ? '0 : (wr_acc && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
    err_d      = err_q || (ld_fire && !ld_ok) || (run && !i_ok) || ((rd_acc || wr_acc) && !d_ok);
  end

  // control and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      inst_in_q  <= '0;
      data_in_q  <= '0;
      err_q      <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      inst_in_q  <= inst_in_d;
      data_in_q  <= data_in_d;
      err_q      <= err_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // memory arrays are never reset; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (ld_fire && ld_ok) imem[ld_addr[IAW-1:0]] <= ld_data;
    if (wr_acc && d_ok) dmem[data_adds[DAW-1:0]] <= data_out;
  end

  assign inst_in   = inst_in_q;
  assign data_in   = data_in_q;
  assign err       = err_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign ld_ready  = state_q == LOAD;
  assign cpu_start = state_q == RUN;
endmodule

// File: tb/tb_simd_mem_responder.sv
// tb_simd_mem_responder: randomized scoreboard bench against a behavioural model of the responder
module tb_simd_mem_responder;
  localparam int DD = 16;
  localparam int ID = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  inst_adds;
  logic [17:0] inst_in;
  logic        data_R, data_W;
  logic [9:0]  data_adds;
  logic [7:0]  data_out, data_in;
  logic        ld_valid, ld_ready;
  logic [9:0]  ld_addr;
  logic [17:0] ld_data;
  logic        ld_last, reload, done, cpu_start, err;
  logic [15:0] rd_count, wr_count;

  always #5 clk = ~clk;

  simd_mem_responder #(.DATA_DEPTH(DD), .INST_DEPTH(ID)) dut (
    .clk(clk), .rst_n(rst_n), .inst_adds(inst_adds), .inst_in(inst_in),
    .data_R(data_R), .data_W(data_W), .data_adds(data_adds), .data_out(data_out),
    .data_in(data_in), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .reload(reload), .done(done),
    .cpu_start(cpu_start), .err(err), .rd_count(rd_count), .wr_count(wr_count)
  );

  typedef struct packed {
    logic [17:0] inst;
    logic [7:0]  din;
    logic        rdy, start, err;
    logic [15:0] rc, wc;
    logic        ik, dk;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int checks = 0;
  int fails = 0;

  int          m_mode;
  logic [17:0] m_im [ID];
  bit          m_ikm [ID];
  logic [7:0]  m_dm [DD];
  bit          m_dkm [DD];
  logic [17:0] m_inst;
  logic [7:0]  m_din;
  bit          m_ik, m_dk, m_err;
  int          m_rc, m_wc;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic mclear();
    m_mode = 0; m_rc = 0; m_wc = 0; m_inst = '0; m_din = '0; m_ik = 1; m_dk = 1;
  endtask

  task automatic chk_reset_now();
    chk("rst_ld_ready", 32'(ld_ready), 1);
    chk("rst_cpu_start", 32'(cpu_start), 0);
    chk("rst_inst_in", 32'(inst_in), 0);
    chk("rst_data_in", 32'(data_in), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rd_count", 32'(rd_count), 0);
    chk("rst_wr_count", 32'(wr_count), 0);
  endtask

  // behavioural model: apply this cycle's inputs, queue the outputs expected after the edge
  task automatic cyc();
    int da, ia, la;
    exp_t e;
    da = int'(data_adds); ia = int'(inst_adds); la = int'(ld_addr);
    if (m_mode == 0) begin
      if (ld_valid) begin
        if (la < ID) begin m_im[la] = ld_data; m_ikm[la] = 1; end else m_err = 1;
        if (ld_last) m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (data_R) begin
        m_rc = (m_rc < 65535) ? m_rc + 1 : m_rc;
        if (da >= DD) begin m_din = '0; m_dk = 1; m_err = 1; end
        else if (data_W) begin m_din = data_out; m_dk = 1; end
        else begin m_din = m_dm[da]; m_dk = m_dkm[da]; end
      end
      if (data_W) begin
        m_wc = (m_wc < 65535) ? m_wc + 1 : m_wc;
        if (da < DD) begin m_dm[da] = data_out; m_dkm[da] = 1; end else m_err = 1;
      end
      if (ia < ID) begin m_inst = m_im[ia]; m_ik = m_ikm[ia]; end
      else begin m_inst = '0; m_ik = 1; m_err = 1; end
      if (reload) mclear();
      else if (done) begin m_mode = 2; m_inst = '0; m_ik = 1; end
    end else if (reload) mclear();
    e.inst = m_inst; e.din = m_din; e.rdy = m_mode == 0; e.start = m_mode == 1;
    e.err = m_err; e.rc = 16'(m_rc); e.wc = 16'(m_wc); e.ik = m_ik; e.dk = m_dk;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic ld(input logic v, input int a, input logic [17:0] d, input logic last);
    ld_valid = v; ld_addr = 10'(a); ld_data = d; ld_last = last;
    data_R = 1'($urandom_range(0, 1)); data_W = 1'($urandom_range(0, 1));
    data_adds = 10'($urandom_range(0, 15)); data_out = 8'($urandom);
    inst_adds = 10'($urandom_range(0, 11));
    reload = 1'($urandom_range(0, 1)); done = 1'($urandom_range(0, 1));
    cyc();
  endtask

  task automatic drv(input logic r, input logic w, input int da, input logic [7:0] dout, input int ia);
    data_R = r; data_W = w; data_adds = 10'(da); data_out = dout; inst_adds = 10'(ia);
    reload = 0; done = 0;
    ld_valid = 1'($urandom_range(0, 1)); ld_addr = 10'($urandom_range(0, 11));
    ld_data = 18'($urandom); ld_last = 1'($urandom_range(0, 1));
    cyc();
  endtask

  task automatic ctl(input logic rl, input logic dn);
    data_R = 0; data_W = 0; inst_adds = '0; ld_valid = 0; ld_last = 0;
    reload = rl; done = dn;
    cyc();
  endtask

  // monitor: one queued expectation per rising edge, sampled just after it
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m_e = q.pop_front();
      if (m_e.ik) chk("inst_in", 32'(inst_in), 32'(m_e.inst));
      if (m_e.dk) chk("data_in", 32'(data_in), 32'(m_e.din));
      chk("ld_ready", 32'(ld_ready), 32'(m_e.rdy));
      chk("cpu_start", 32'(cpu_start), 32'(m_e.start));
      chk("err", 32'(err), 32'(m_e.err));
      chk("rd_count", 32'(rd_count), 32'(m_e.rc));
      chk("wr_count", 32'(wr_count), 32'(m_e.wc));
    end
  end

  initial begin
    int perm [ID];
    rst_n = 0; ld_valid = 0; ld_addr = '0; ld_data = '0; ld_last = 0; reload = 0; done = 0;
    data_R = 0; data_W = 0; data_adds = '0; data_out = '0; inst_adds = '0;
    m_err = 0; mclear();
    #1; chk_reset_now();
    @(negedge clk); rst_n = 1;
    ld(1, 0, 18'h00001, 0); ld(1, 1, 18'h00002, 0); ld(1, 2, 18'h3F000, 1);
    drv(0, 0, 0, 8'h00, 2);
    drv(0, 1, 5, 8'hA5, 2);
    drv(1, 0, 5, 8'h00, 2);
    drv(1, 1, 7, 8'h3C, 0);
    drv(1, 0, 7, 8'h00, 1);
    for (int i = 0; i < DD; i++) drv(0, 1, i, 8'($urandom), $urandom_range(0, 2));
    repeat (200) drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                     8'($urandom), $urandom_range(0, 2));
    ctl(0, 1);
    repeat (5) drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                   8'($urandom), $urandom_range(0, 2));
    ctl(1, 0);
    ld(0, 0, '0, 0);
    for (int i = 0; i < ID; i++) perm[i] = i;
    for (int i = ID - 1; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < ID; i++) begin
      if ($urandom_range(0, 2) == 0) ld(0, 0, '0, 1);
      ld(1, perm[i], 18'($urandom), 1'(i == ID - 1));
    end
    drv(0, 1, 20, 8'h77, 0);
    drv(1, 0, 20, 8'h00, 0);
    repeat (300) drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 4) == 0) ? $urandom_range(16, 1023) : $urandom_range(0, 15),
                     8'($urandom),
                     ($urandom_range(0, 7) == 0) ? $urandom_range(12, 1023) : $urandom_range(0, 11));
    ctl(1, 1);
    ld(1, 700, 18'h12345, 0);
    ld(1, 0, 18'($urandom), 1);
    repeat (65540) drv(1, 1, $urandom_range(0, 15), 8'($urandom), $urandom_range(0, 11));
    drv(1, 0, 3, 8'h00, 4);
    data_R = 0; data_W = 0; ld_valid = 0; reload = 0; done = 0;
    rst_n = 0;
    #1; chk_reset_now();
    m_err = 0; mclear();
    @(negedge clk); rst_n = 1;
    ld(0, 0, '0, 0);
    ld(1, 3, 18'($urandom), 1);
    repeat (20) drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                    8'($urandom), $urandom_range(0, 11));
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drain", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
